serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 20 ++
 rtl/sub_digit.sv | 26 ++
 rtl/serial_subtractor.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the digit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits processed per operation.
  function automatic int digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter width for n digits; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit ripple subtractor: d = a - b - bin, bout = borrow out of the top bit.
module sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] borrow;

  assign borrow[0] = bin;

  genvar gi;
  generate
    for (gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign d[gi]          = a[gi] ^ b[gi] ^ borrow[gi];
      assign borrow[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow[gi]);
    end
  endgenerate

  assign bout = borrow[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor with valid/ready handshakes on both sides.
// Optional signed flags (ovf, neg) are built only when SUB_SIGNED_FLAGS_EN is defined.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_FLAGS_EN
  ,
  output logic             ovf,
  output logic             neg
`endif
);

  localparam int N  = digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;
  logic             bout_reg;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_dig;
  logic             dig_bout;

`ifdef SUB_SIGNED_FLAGS_EN
  logic ovf_reg;
  logic neg_reg;
`endif

  // Operands stay put after capture; the counter selects the active digit.
  assign a_dig = a_reg[int'(cnt_reg) * DIGIT +: DIGIT];
  assign b_dig = b_reg[int'(cnt_reg) * DIGIT +: DIGIT];

  sub_digit #(
    .DIGIT(DIGIT)
  ) u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .bin  (borrow_reg),
    .d    (d_dig),
    .bout (dig_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
`ifdef SUB_SIGNED_FLAGS_EN
      ovf_reg    <= 1'b0;
      neg_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= a;
            b_reg      <= b;
            borrow_reg <= bin;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          diff_reg[int'(cnt_reg) * DIGIT +: DIGIT] <= d_dig;
          borrow_reg <= dig_bout;
          if (cnt_reg == LAST) begin
            // Final digit: latch the visible borrow and flags together with the top digit.
            bout_reg  <= dig_bout;
`ifdef SUB_SIGNED_FLAGS_EN
            ovf_reg   <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (d_dig[DIGIT-1] != a_reg[WIDTH-1]);
            neg_reg   <= d_dig[DIGIT-1];
`endif
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign diff      = diff_reg;
  assign bout      = bout_reg;

`ifdef SUB_SIGNED_FLAGS_EN
  assign ovf = ovf_reg;
  assign neg = neg_reg;
`endif

endmodule
